// File: rtl/parking_entry_frontend.sv
// Input conditioning ahead of the parking controller: debounces both vehicle
// sensors and captures a two-digit keypad password with a first-to-second timeout.
module parking_entry_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entrance_raw,
    input  logic       sensor_exit_raw,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    input  logic       pw_consume,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_valid,
    output logic       pw_timeout,
    output logic [1:0] digit_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GOT_FIRST, HOLD} pw_state_t;

    pw_state_t       state;
    logic [TW-1:0]   to_cnt;
    logic [1:0]      raw_s;
    logic [1:0]      out_s;
    logic [1:0][7:0] db_cnt;

    assign raw_s           = {sensor_exit_raw, sensor_entrance_raw};
    assign sensor_entrance = out_s[0];
    assign sensor_exit     = out_s[1];

    // Bit 0 is the entrance sensor, bit 1 the exit sensor; any sample matching
    // the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_s  <= '0;
            db_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (raw_s[i] == out_s[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    out_s[i]  <= ~out_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            password_1  <= '0;
            password_2  <= '0;
            pw_valid    <= 1'b0;
            pw_timeout  <= 1'b0;
            digit_count <= '0;
        end else begin
            pw_timeout <= 1'b0;
            if (key_clear) begin
                state       <= IDLE;
                to_cnt      <= '0;
                password_1  <= '0;
                password_2  <= '0;
                pw_valid    <= 1'b0;
                digit_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_valid) begin
                            password_1  <= key_digit;
                            to_cnt      <= '0;
                            digit_count <= 2'd1;
                            state       <= GOT_FIRST;
                        end
                    end
                    GOT_FIRST: begin
                        // A digit arriving on the final allowed cycle still wins.
                        if (key_valid) begin
                            password_2  <= key_digit;
                            to_cnt      <= '0;
                            pw_valid    <= 1'b1;
                            digit_count <= 2'd2;
                            state       <= HOLD;
                        end else if (to_cnt == TO_LAST) begin
                            pw_timeout  <= 1'b1;
                            password_1  <= '0;
                            to_cnt      <= '0;
                            digit_count <= '0;
                            state       <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (pw_consume) begin
                            password_1  <= '0;
                            password_2  <= '0;
                            pw_valid    <= 1'b0;
                            digit_count <= '0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Bench for parking_entry_frontend: a sample-history / queue reference model
// checked every cycle, plus directed literal expectations.
module tb_parking_entry_frontend;

    localparam int DB = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_entrance_raw = 1'b0;
    logic       sensor_exit_raw = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_digit = 2'd0;
    logic       key_clear = 1'b0;
    logic       pw_consume = 1'b0;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pw_valid;
    logic       pw_timeout;
    logic [1:0] digit_count;

    int tests = 0;
    int failed = 0;

    parking_entry_frontend #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .sensor_entrance_raw(sensor_entrance_raw),
        .sensor_exit_raw(sensor_exit_raw),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_clear(key_clear),
        .pw_consume(pw_consume),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .password_1(password_1),
        .password_2(password_2),
        .pw_valid(pw_valid),
        .pw_timeout(pw_timeout),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sensor level flips once the last DB samples all
    // disagree with it; the password is a queue of captured digits.
    bit live = 1'b0;
    bit hist [2][DB];
    int filled [2];
    bit m_sens [2];
    int pw_q[$];
    int elapsed;
    bit m_to;

    always @(posedge clk) begin
        bit raws [2];
        bit all_diff;
        raws[0] = sensor_entrance_raw;
        raws[1] = sensor_exit_raw;
        if (reset) begin
            live = 1'b1;
            for (int s = 0; s < 2; s++) begin
                filled[s] = 0;
                m_sens[s] = 1'b0;
            end
            pw_q.delete();
            elapsed = 0;
            m_to = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                for (int k = DB - 1; k > 0; k--) hist[s][k] = hist[s][k-1];
                hist[s][0] = raws[s];
                if (filled[s] < DB) filled[s]++;
                if (filled[s] == DB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DB; k++)
                        if (hist[s][k] == m_sens[s]) all_diff = 1'b0;
                    if (all_diff) m_sens[s] = !m_sens[s];
                end
            end
            m_to = 1'b0;
            if (key_clear) begin
                pw_q.delete();
                elapsed = 0;
            end else if (pw_q.size() == 2) begin
                if (pw_consume) pw_q.delete();
            end else if (pw_q.size() == 1) begin
                if (key_valid) pw_q.push_back(int'(key_digit));
                else if (elapsed == TO - 1) begin
                    m_to = 1'b1;
                    pw_q.delete();
                end else elapsed++;
            end else if (key_valid) begin
                pw_q.push_back(int'(key_digit));
                elapsed = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model sensor_entrance", 32'(sensor_entrance), 32'(m_sens[0]));
            chk("model sensor_exit", 32'(sensor_exit), 32'(m_sens[1]));
            chk("model password_1", 32'(password_1), (pw_q.size() >= 1) ? pw_q[0] : 0);
            chk("model password_2", 32'(password_2), (pw_q.size() == 2) ? pw_q[1] : 0);
            chk("model pw_valid", 32'(pw_valid), (pw_q.size() == 2) ? 1 : 0);
            chk("model pw_timeout", 32'(pw_timeout), 32'(m_to));
            chk("model digit_count", 32'(digit_count), pw_q.size());
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic pw_expect(input string name, input int p1, input int p2, input int v, input int c);
        chk({name, " password_1"}, 32'(password_1), p1);
        chk({name, " password_2"}, 32'(password_2), p2);
        chk({name, " pw_valid"}, 32'(pw_valid), v);
        chk({name, " digit_count"}, 32'(digit_count), c);
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        pw_expect("reset", 0, 0, 0, 0);
        chk("reset sensor_entrance", 32'(sensor_entrance), 0);
        chk("reset pw_timeout", 32'(pw_timeout), 0);

        // Debounce rise and fall on the entrance sensor.
        sensor_entrance_raw = 1'b1;
        step(3);
        chk("ent rise edge3", 32'(sensor_entrance), 0);
        step(1);
        chk("ent rise edge4", 32'(sensor_entrance), 1);
        sensor_entrance_raw = 1'b0;
        step(3);
        chk("ent fall edge3", 32'(sensor_entrance), 1);
        step(1);
        chk("ent fall edge4", 32'(sensor_entrance), 0);

        // Glitch on the exit sensor restarts the count.
        sensor_exit_raw = 1'b1;
        step(3);
        chk("exit high3", 32'(sensor_exit), 0);
        sensor_exit_raw = 1'b0;
        step(1);
        chk("exit glitch", 32'(sensor_exit), 0);
        sensor_exit_raw = 1'b1;
        step(3);
        chk("exit rerun3", 32'(sensor_exit), 0);
        step(1);
        chk("exit rerun4", 32'(sensor_exit), 1);
        sensor_exit_raw = 1'b0;
        step(4);

        // Normal capture, ignored third key, consume.
        press(2'd1);
        pw_expect("first digit", 1, 0, 0, 1);
        step(4);
        press(2'd2);
        pw_expect("hold", 1, 2, 1, 2);
        press(2'd3);
        pw_expect("hold third key", 1, 2, 1, 2);
        pw_consume = 1'b1;
        step(1);
        pw_consume = 1'b0;
        pw_expect("consumed", 0, 0, 0, 0);

        // Timeout after TO cycles without a second digit.
        press(2'd3);
        step(TO - 1);
        pw_expect("pre-timeout", 3, 0, 0, 1);
        chk("pre-timeout pulse", 32'(pw_timeout), 0);
        step(1);
        chk("timeout pulse", 32'(pw_timeout), 1);
        pw_expect("timeout", 0, 0, 0, 0);
        step(1);
        chk("timeout pulse width", 32'(pw_timeout), 0);

        // Second digit on the last allowed cycle is accepted.
        press(2'd3);
        step(TO - 1);
        press(2'd0);
        pw_expect("late key", 3, 0, 1, 2);
        chk("late key no pulse", 32'(pw_timeout), 0);
        pw_consume = 1'b1;
        step(1);
        pw_consume = 1'b0;

        // key_clear beats a simultaneous key_valid; no later timeout.
        press(2'd2);
        step(3);
        key_clear = 1'b1;
        press(2'd1);
        key_clear = 1'b0;
        pw_expect("clear", 0, 0, 0, 0);
        step(TO + 5);
        pw_consume = 1'b1;
        step(1);
        pw_consume = 1'b0;
        pw_expect("consume in idle", 0, 0, 0, 0);

        // Reset during HOLD and mid-debounce, then a fresh entry.
        press(2'd2);
        press(2'd1);
        pw_expect("hold 2,1", 2, 1, 1, 2);
        sensor_entrance_raw = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        pw_expect("reset in hold", 0, 0, 0, 0);
        step(2);
        chk("debounce restarted by reset", 32'(sensor_entrance), 0);
        step(2);
        chk("debounce after reset", 32'(sensor_entrance), 1);
        press(2'd0);
        press(2'd3);
        pw_expect("after reset 0,3", 0, 3, 1, 2);
        key_clear = 1'b1;
        step(1);
        key_clear = 1'b0;
        pw_expect("clear in hold", 0, 0, 0, 0);

        // Sparse sensor activity alongside key traffic, checked by the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) sensor_entrance_raw = ~sensor_entrance_raw;
            if ($urandom_range(0, 4) == 0) sensor_exit_raw = ~sensor_exit_raw;
            key_valid  = ($urandom_range(0, 15) == 0);
            key_digit  = 2'($urandom_range(0, 3));
            pw_consume = ($urandom_range(0, 7) == 0);
            key_clear  = ($urandom_range(0, 40) == 0);
            step(1);
        end
        key_valid = 1'b0;
        pw_consume = 1'b0;
        key_clear = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
